// File: rtl/gc_poll_sequencer.sv
// GameCube controller poll sequencer: sends the 24-bit poll command on the
// open-drain controller bus and collects the 64-bit status response.
//
// state     | meaning
// IDLE      | bus released, waiting for a timer or poll_now request
// TX_LOW    | command bit low phase (3U for '0', 1U for '1')
// TX_HIGH   | command bit high phase (1U for '0', 3U for '1')
// TX_STOP   | 1U low stop pulse after the last command bit
// RX_WAIT   | waiting for the controller's falling edge (timed)
// RX_SAMPLE | 2U after the edge, sample the bit value
// RX_HIGH   | waiting for the line to return high (timed)
// DONE      | publish the status word
// ERR       | response timed out, raise the sticky flag
module gc_poll_sequencer #(
  parameter int CLK_PER_US     = 10,
  parameter int POLL_PERIOD_US = 10000,
  parameter int TIMEOUT_US     = 100
) (
  input  logic        SYSCLK,
  input  logic        NSYSRESET,
  input  logic        enable,
  input  logic        poll_now,
  input  logic        rumble,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy,
  output logic        status_valid,
  output logic [63:0] status_data,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int U        = CLK_PER_US;
  localparam int POLL_CYC = POLL_PERIOD_US * U;
  localparam int TO_CYC   = TIMEOUT_US * U;
  localparam int CNT_MAX  = (3 * U > TO_CYC) ? 3 * U : TO_CYC;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int TW       = $clog2(POLL_CYC + 1);

  localparam logic [CW-1:0] CNT_1U = CW'(U - 1);
  localparam logic [CW-1:0] CNT_2U = CW'(2 * U - 1);
  localparam logic [CW-1:0] CNT_3U = CW'(3 * U - 1);
  localparam logic [CW-1:0] CNT_TO = CW'(TO_CYC - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_SAMPLE, RX_HIGH, DONE, ERR
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          pending;
  logic [23:0]   cmd;
  logic [23:0]   cmd_new;
  logic [4:0]    bit_idx, bit_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [6:0]    rx_cnt, rx_cnt_nxt;
  logic [63:0]   shreg;
  logic [2:0]    sync_q;
  logic          rx_line, rx_fall;
  logic          timer_tc, start_req;
  logic          launch, shift_en, done_evt, err_evt, oe_nxt;

  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? CNT_1U : CNT_3U;
  endfunction

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? CNT_3U : CNT_1U;
  endfunction

  assign cmd_new   = {16'h4003, 7'b0000001, rumble};
  assign rx_line   = sync_q[1];
  assign rx_fall   = sync_q[2] & ~sync_q[1];
  assign timer_tc  = enable && (timer == TIMER_LAST);
  assign start_req = poll_now | timer_tc;
  assign busy      = (state != IDLE);

  // two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) sync_q <= 3'b111;
    else            sync_q <= {sync_q[1:0], data_in};
  end

  // free-running auto-poll timer, held at zero while disabled
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET)    timer <= '0;
    else if (!enable)  timer <= '0;
    else if (timer_tc) timer <= '0;
    else               timer <= timer + TW'(1);
  end

  // single-deep request queue for requests arriving mid-transaction
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET)         pending <= 1'b0;
    else if (state == IDLE) pending <= 1'b0;
    else if (start_req)     pending <= 1'b1;
  end

  // state register
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) state <= IDLE;
    else            state <= state_nxt;
  end

  // next-state, phase counter loads and event strobes
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt != '0) ? cnt - CW'(1) : cnt;
    bit_nxt    = bit_idx;
    rx_cnt_nxt = rx_cnt;
    launch     = 1'b0;
    shift_en   = 1'b0;
    done_evt   = 1'b0;
    err_evt    = 1'b0;
    case (state)
      IDLE: if (start_req || pending) begin
        launch    = 1'b1;
        state_nxt = TX_LOW;
        bit_nxt   = 5'd23;
        cnt_nxt   = low_len(cmd_new[23]);
      end
      TX_LOW: if (cnt == '0) begin
        state_nxt = TX_HIGH;
        cnt_nxt   = high_len(cmd[bit_idx]);
      end
      TX_HIGH: if (cnt == '0) begin
        if (bit_idx == 5'd0) begin
          state_nxt = TX_STOP;
          cnt_nxt   = CNT_1U;
        end else begin
          state_nxt = TX_LOW;
          bit_nxt   = bit_idx - 5'd1;
          cnt_nxt   = low_len(cmd[bit_idx - 5'd1]);
        end
      end
      TX_STOP: if (cnt == '0) begin
        state_nxt  = RX_WAIT;
        cnt_nxt    = CNT_TO;
        rx_cnt_nxt = 7'd0;
      end
      RX_WAIT: begin
        if (rx_fall) begin
          state_nxt = RX_SAMPLE;
          cnt_nxt   = CNT_2U;
        end else if (cnt == '0) begin
          state_nxt = ERR;
        end
      end
      RX_SAMPLE: if (cnt == '0) begin
        shift_en   = 1'b1;
        rx_cnt_nxt = rx_cnt + 7'd1;
        state_nxt  = RX_HIGH;
        cnt_nxt    = CNT_TO;
      end
      RX_HIGH: begin
        if (rx_line) begin
          if (rx_cnt == 7'd64) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RX_WAIT;
            cnt_nxt   = CNT_TO;
          end
        end else if (cnt == '0) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        done_evt  = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err_evt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    oe_nxt = (state_nxt == TX_LOW) || (state_nxt == TX_STOP);
  end

  // transaction datapath; data_oe is registered so the pad never sees decode glitches
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      cnt     <= '0;
      bit_idx <= 5'd0;
      rx_cnt  <= 7'd0;
      cmd     <= '0;
      shreg   <= '0;
      data_oe <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      rx_cnt  <= rx_cnt_nxt;
      data_oe <= oe_nxt;
      if (launch)   cmd   <= cmd_new;
      if (shift_en) shreg <= {shreg[62:0], rx_line};
    end
  end

  // published status and sticky timeout flag; a new error beats err_clr
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      status_valid <= 1'b0;
      status_data  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      status_valid <= done_evt;
      if (done_evt) status_data <= shreg;
      if (err_evt)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gc_poll_sequencer.sv
// Directed bench for gc_poll_sequencer with an open-drain bus model and a
// scripted controller responder.
module tb_gc_poll_sequencer;

  logic        SYSCLK = 1'b0;
  logic        NSYSRESET = 1'b0;
  logic        enable = 1'b0;
  logic        poll_now = 1'b0;
  logic        rumble = 1'b0;
  logic        err_clr = 1'b0;
  logic        data_in;
  logic        data_oe, busy, status_valid, timeout_err;
  logic [63:0] status_data;

  logic ctl_low = 1'b0;
  logic tog_en  = 1'b0;
  logic tog_val = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;
  int sv_count = 0;
  int sv_cyc = 0;
  logic sv_busy = 1'b0;
  logic [63:0] sv_data = '0;
  int t_start = 0;

  logic trace [0:999];
  logic mdl   [0:999];

  localparam logic [63:0] RESP = 64'h0080_8080_8080_0000;

  gc_poll_sequencer #(
    .CLK_PER_US(10), .POLL_PERIOD_US(300), .TIMEOUT_US(100)
  ) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .enable(enable), .poll_now(poll_now),
    .rumble(rumble), .data_in(data_in), .data_oe(data_oe), .busy(busy),
    .status_valid(status_valid), .status_data(status_data),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  assign data_in = tog_en ? tog_val : ~(data_oe | ctl_low);

  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  always @(negedge SYSCLK) begin
    if (status_valid === 1'b1) begin
      sv_count++;
      sv_cyc  = cyc;
      sv_busy = busy;
      sv_data = status_data;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rel(input int at, input int ref_cyc);
    return (at < 0) ? -1 : at - ref_cyc;
  endfunction

  task automatic wait_sig(input int sel, input logic lvl, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      logic v;
      @(negedge SYSCLK);
      case (sel)
        0:       v = busy;
        1:       v = timeout_err;
        default: v = status_valid;
      endcase
      if (v === lvl) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_poll();
    poll_now = 1'b1;
    @(negedge SYSCLK);
    poll_now = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge SYSCLK);
    err_clr = 1'b0;
  endtask

  task automatic build_model(input logic [23:0] c);
    int idx = 0;
    for (int b = 23; b >= 0; b--) begin
      int lo;
      lo = c[b] ? 10 : 30;
      for (int j = 0; j < lo; j++) begin mdl[idx] = 1'b1; idx++; end
      for (int j = 0; j < 40 - lo; j++) begin mdl[idx] = 1'b0; idx++; end
    end
    for (int j = 0; j < 10; j++) begin mdl[idx] = 1'b1; idx++; end
    while (idx < 1000) begin mdl[idx] = 1'b0; idx++; end
  endtask

  // launch with poll_now and record data_oe for 1000 cycles from the first busy cycle
  task automatic launch_and_capture(input string tag);
    pulse_poll();
    t_start = cyc;
    check_val({tag, "_launch_busy"}, busy, 1);
    for (int i = 0; i < 1000; i++) begin
      trace[i] = data_oe;
      @(negedge SYSCLK);
    end
  endtask

  function automatic int run_len(input int start);
    int n = 0;
    logic v;
    v = trace[start];
    for (int i = start; i < 1000; i++) begin
      if (trace[i] !== v) break;
      n++;
    end
    return n;
  endfunction

  function automatic int first_zero(input int start);
    for (int i = start; i < 1000; i++) if (trace[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int trace_diff();
    int d = 0;
    for (int i = 0; i < 1000; i++) if (trace[i] !== mdl[i]) d++;
    return d;
  endfunction

  task automatic respond(input logic [63:0] w);
    int n = 0;
    while (busy !== 1'b1 && n < 100) begin @(negedge SYSCLK); n++; end
    repeat (990) @(negedge SYSCLK);
    for (int k = 63; k >= 0; k--) begin
      ctl_low = 1'b1;
      repeat (w[k] ? 10 : 30) @(negedge SYSCLK);
      ctl_low = 1'b0;
      repeat (w[k] ? 30 : 10) @(negedge SYSCLK);
    end
    ctl_low = 1'b1;
    repeat (10) @(negedge SYSCLK);
    ctl_low = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, t0, sv_before;

    // reset held with a toggling pad and active requests
    tog_en   = 1'b1;
    poll_now = 1'b1;
    enable   = 1'b1;
    repeat (20) begin
      @(negedge SYSCLK);
      tog_val = ~tog_val;
    end
    check_val("rst_data_oe", data_oe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_status_valid", status_valid, 0);
    check_val("rst_status_data", status_data, 0);
    check_val("rst_timeout_err", timeout_err, 0);
    poll_now = 1'b0;
    enable   = 1'b0;
    tog_en   = 1'b0;
    @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    repeat (5) @(negedge SYSCLK);
    check_val("rst_idle_after", busy, 0);

    // A: rumble=0 command timing, then no response -> timeout
    rumble = 1'b0;
    build_model(24'h400302);
    launch_and_capture("a");
    check_val("a_bit23_oe_level", trace[0], 1);
    check_val("a_bit23_oe_high", run_len(0), 30);
    check_val("a_bit23_oe_low", run_len(30), 10);
    check_val("a_bit22_oe_high", run_len(40), 10);
    check_val("a_bit22_oe_low", run_len(50), 30);
    check_val("a_release_idx", first_zero(960), 970);
    check_val("a_tx_pattern_diff", trace_diff(), 0);
    wait_sig(1, 1'b1, 2000, at);
    check_val("a_timeout_at", rel(at, t_start), 1971);
    check_val("a_busy_after_err", busy, 0);
    check_val("a_no_valid", sv_count, 0);
    check_val("a_status_kept", status_data, 0);
    pulse_clr();
    check_val("a_err_clr", timeout_err, 0);

    // B: rumble=1 command, controller answers RESP
    rumble = 1'b1;
    build_model(24'h400303);
    fork
      launch_and_capture("b");
      respond(RESP);
    join
    repeat (50) @(negedge SYSCLK);
    check_val("b_tx_pattern_diff", trace_diff(), 0);
    check_val("b_bit0_oe_high", run_len(920), 10);
    check_val("b_bit0_oe_low", run_len(930), 30);
    check_val("b_valid_count", sv_count, 1);
    check_val("b_valid_at", rel(sv_cyc, t_start), 3544);
    check_val("b_busy_at_valid", sv_busy, 0);
    check_val("b_status_at_valid", sv_data, RESP);
    check_val("b_status_data", status_data, RESP);
    check_val("b_no_err", timeout_err, 0);

    // C: auto-poll timer plus requests queued while busy
    rumble = 1'b0;
    enable = 1'b1;
    t0 = cyc;
    repeat (1000) @(negedge SYSCLK);
    pulse_poll();
    check_val("c_poll_launch", busy, 1);
    wait_sig(0, 1'b0, 3000, at);
    check_val("c_poll_end", rel(at, t0), 2972);
    wait_sig(0, 1'b1, 100, at);
    check_val("c_timer_launch", rel(at, t0), 3000);
    repeat (100) @(negedge SYSCLK);
    pulse_poll();
    repeat (100) @(negedge SYSCLK);
    pulse_poll();
    wait_sig(0, 1'b0, 2500, at);
    check_val("c_first_end", rel(at, t0), 4971);
    wait_sig(0, 1'b1, 5, at);
    check_val("c_queued_launch", rel(at, t0), 4972);
    enable = 1'b0;
    wait_sig(0, 1'b0, 2500, at);
    check_val("c_queued_end", rel(at, t0), 6943);
    wait_sig(0, 1'b1, 4000, at);
    check_val("c_no_extra_launch", at, -1);
    check_val("c_status_kept", status_data, RESP);
    pulse_clr();
    check_val("c_err_clr", timeout_err, 0);

    // D: asynchronous reset in the middle of TX_LOW
    pulse_poll();
    check_val("d_launch", busy, 1);
    repeat (5) @(negedge SYSCLK);
    check_val("d_in_tx_low", data_oe, 1);
    sv_before = sv_count;
    NSYSRESET = 1'b0;
    #1;
    check_val("d_oe_async", data_oe, 0);
    check_val("d_busy_async", busy, 0);
    check_val("d_status_async", status_data, 0);
    @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    wait_sig(0, 1'b1, 2500, at);
    check_val("d_no_resume", at, -1);
    check_val("d_no_valid", sv_count, sv_before);
    check_val("d_status_zero", status_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
